uart_tx_arbiter: RTL and testbench

Shares the single UART transmitter between `N_REQ` byte producers: the ALU result path, a status/echo source, and future sources. It accepts one byte at a time from the winning requester and drives the UART transmitter's start strobe and data bus. It then holds the transmitter until the UART reports the frame done. It sits between the ALU interface logic and the UART's `i_ready`/`i_din`/`o_tx_done_tick` ports.

---
 rtl/uart_tx_arbiter.sv | 149 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between N_REQ byte producers, one frame at a time.
// Define UART_TX_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module uart_tx_arbiter #(
  parameter int N_REQ  = 2,
  parameter int N_BITS = 8
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic [N_REQ-1:0]        i_req_valid,
  input  logic [N_REQ*N_BITS-1:0] i_req_data,
  output logic [N_REQ-1:0]        o_req_ready,
  output logic [N_REQ-1:0]        o_grant,
  output logic                    o_tx_start,
  output logic [N_BITS-1:0]       o_tx_data,
  input  logic                    i_tx_done_tick,
  output logic                    o_busy
);

  localparam int PTR_W = ($clog2(N_REQ) > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [N_REQ-1:0]    grant_d, ready_d;
  logic                start_d, busy_d;
  logic [N_BITS-1:0]   data_d;

  logic [PTR_W-1:0]    ptr_val;
  logic [N_REQ-1:0]    rot_valid;
  logic                win_found;
  logic [PTR_W-1:0]    win_idx;
  logic [N_REQ-1:0]    win_oh;
  logic [N_BITS-1:0]   win_data;

  // Map an index in [0, 2*N_REQ) back into [0, N_REQ).
  function automatic logic [PTR_W-1:0] wrap_idx(input int idx);
    if (idx >= N_REQ) return PTR_W'(idx - N_REQ);
    return PTR_W'(idx);
  endfunction

`ifdef UART_TX_ARB_RR_EN
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  assign ptr_val = ptr_q;
`else
  assign ptr_val = '0;
`endif

  // Rotate so that the highest-priority requester sits at bit 0.
  assign rot_valid = N_REQ'({i_req_valid, i_req_valid} >> ptr_val);

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_found && rot_valid[i]) begin
        win_found = 1'b1;
        win_idx   = wrap_idx(int'(ptr_val) + i);
      end
    end
  end

  assign win_oh = N_REQ'(1) << win_idx;

  always_comb begin
    win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_oh[i]) win_data = i_req_data[i*N_BITS +: N_BITS];
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    grant_d = o_grant;
    data_d  = o_tx_data;
    busy_d  = o_busy;
    ready_d = '0;
    start_d = 1'b0;
`ifdef UART_TX_ARB_RR_EN
    ptr_d   = ptr_q;
    owner_d = owner_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          data_d  = win_data;
          grant_d = win_oh;
          ready_d = win_oh;
          start_d = 1'b1;
          busy_d  = 1'b1;
          state_d = START;
`ifdef UART_TX_ARB_RR_EN
          owner_d = win_idx;
`endif
        end
      end
      // A done tick here belongs to an earlier frame and is ignored.
      START: state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (i_tx_done_tick) begin
          grant_d = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
`ifdef UART_TX_ARB_RR_EN
          ptr_d   = wrap_idx(int'(owner_q) + 1);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= IDLE;
      o_grant     <= '0;
      o_req_ready <= '0;
      o_tx_start  <= 1'b0;
      o_tx_data   <= '0;
      o_busy      <= 1'b0;
    end else begin
      state_q     <= state_d;
      o_grant     <= grant_d;
      o_req_ready <= ready_d;
      o_tx_start  <= start_d;
      o_tx_data   <= data_d;
      o_busy      <= busy_d;
    end
  end

`ifdef UART_TX_ARB_RR_EN
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised and directed bench for uart_tx_arbiter against a transaction-level reference model.
// Works for both arbitration builds (UART_TX_ARB_RR_EN defined or not).
module tb_uart_tx_arbiter;

  localparam int N_REQ  = 2;
  localparam int N_BITS = 8;
  localparam int DW     = N_REQ * N_BITS;

  typedef enum int {RQ_HOLD, RQ_ONESHOT, RQ_RANDOM} rq_mode_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [N_REQ-1:0]  rq_valid;
  logic [DW-1:0]     rq_data;
  logic              done;
  logic [N_REQ-1:0]  o_req_ready, o_grant;
  logic              o_tx_start, o_busy;
  logic [N_BITS-1:0] o_tx_data;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N_REQ), .N_BITS(N_BITS)) dut (
    .i_clock        (clk),
    .i_reset        (rst_n),
    .i_req_valid    (rq_valid),
    .i_req_data     (rq_data),
    .o_req_ready    (o_req_ready),
    .o_grant        (o_grant),
    .o_tx_start     (o_tx_start),
    .o_tx_data      (o_tx_data),
    .i_tx_done_tick (done),
    .o_busy         (o_busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: owner index (-1 = transmitter free) and cycles since acceptance.
  int                m_owner = -1;
  int                m_age   = 0;
  int                m_ptr   = 0;
  logic [N_BITS-1:0] m_data  = '0;
  int                n_acc   = 0;

  rq_mode_t          mode = RQ_ONESHOT;
  int                uart_cnt = 0;
  int                uart_lat = 20;
  bit                rand_lat = 1'b0;
  logic              force_done = 1'b0;
  logic              last_done = 1'b0;
  int                n_starts = 0;
  int                n_ready = 0;
  logic [N_BITS-1:0] tx_log[$];

  function automatic int pick(input logic [N_REQ-1:0] v);
    int idx;
    for (int k = 0; k < N_REQ; k++) begin
`ifdef UART_TX_ARB_RR_EN
      idx = (m_ptr + k) % N_REQ;
`else
      idx = k;
`endif
      if (((v >> idx) & 1) != 0) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_age   = 0;
    m_ptr   = 0;
    m_data  = '0;
  endtask

  task automatic model_edge();
    int w;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_owner >= 0) begin
      if (m_age >= 1 && done) begin
        m_ptr   = (m_owner + 1) % N_REQ;
        m_owner = -1;
      end else begin
        m_age++;
      end
    end else begin
      w = pick(rq_valid);
      if (w >= 0) begin
        m_owner = w;
        m_age   = 0;
        m_data  = N_BITS'(rq_data >> (w * N_BITS));
        n_acc++;
      end
    end
  endtask

  function automatic logic exp_start();
    return (m_owner >= 0) && (m_age == 0);
  endfunction

  function automatic logic [N_REQ-1:0] exp_grant();
    return (m_owner >= 0) ? N_REQ'(1 << m_owner) : '0;
  endfunction

  task automatic compare_all();
    check("grant", o_grant, exp_grant());
    check("busy", o_busy, m_owner >= 0);
    check("tx_start", o_tx_start, exp_start());
    check("req_ready", o_req_ready, exp_start() ? exp_grant() : '0);
    check("tx_data", o_tx_data, m_data);
    if (o_tx_start) begin
      n_starts++;
      tx_log.push_back(o_tx_data);
    end
    if (o_req_ready != '0) n_ready++;
  endtask

  // Requester and UART behaviour after each edge, driven from the model's view of consumption.
  task automatic post_edge();
    logic consumed;
    for (int r = 0; r < N_REQ; r++) begin
      consumed = exp_start() && (m_owner == r);
      case (mode)
        RQ_ONESHOT: if (consumed) rq_valid[r] = 1'b0;
        RQ_RANDOM: begin
          if (consumed) begin
            rq_valid[r] = 1'($urandom_range(0, 1));
            rq_data[r*N_BITS +: N_BITS] = N_BITS'($urandom);
          end else if (!rq_valid[r]) begin
            rq_data[r*N_BITS +: N_BITS] = N_BITS'($urandom);
            rq_valid[r] = ($urandom_range(0, 3) == 0);
          end
        end
        default: ;
      endcase
    end
    if (exp_start()) uart_cnt = rand_lat ? int'($urandom_range(2, 25)) : uart_lat;
  endtask

  task automatic step();
    done = force_done;
    force_done = 1'b0;
    if (uart_cnt > 0) begin
      uart_cnt--;
      if (uart_cnt == 0) done = 1'b1;
    end
    last_done = done;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    post_edge();
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    int n = 0;
    while (o_busy && n < max_cyc) begin
      step();
      n++;
    end
    check(tag, o_busy, 1'b0);
  endtask

  task automatic do_reset(input int hold);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    repeat (hold) step();
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    int n;
    logic [N_BITS-1:0] exp_seq[4];

    rq_valid = '0;
    rq_data  = '0;
    done     = 1'b0;

    // Async reset: outputs must clear without a clock edge.
    #2;
    do_reset(3);
    step();

    // Single request from requester 1, 20-cycle frame.
    mode = RQ_ONESHOT;
    uart_lat = 20;
    rq_data = {8'h3C, 8'h00};
    rq_valid = 2'b10;
    step();
    check("single_start", o_tx_start, 1'b1);
    check("single_ready", o_req_ready, 2'b10);
    check("single_data", o_tx_data, 8'h3C);
    check("single_grant", o_grant, 2'b10);
    n = 0;
    while (o_busy && n < 60) begin
      step();
      n++;
    end
    check("single_frame_len", n, 20);
    check("single_grant_after", o_grant, 2'b00);

    // Both requesters continuously valid.
    mode = RQ_HOLD;
    uart_lat = 6;
    tx_log.delete();
    n_ready = 0;
    rq_data = {8'hB2, 8'hA1};
    rq_valid = 2'b11;
`ifdef UART_TX_ARB_RR_EN
    exp_seq = '{8'hA1, 8'hB2, 8'hA1, 8'hB2};
`else
    exp_seq = '{8'hA1, 8'hA1, 8'hA1, 8'hB2};
`endif
    n = 0;
    while (tx_log.size() < 4 && n < 300) begin
      step();
      n++;
`ifndef UART_TX_ARB_RR_EN
      if (tx_log.size() == 3 && rq_valid[0]) rq_valid[0] = 1'b0;
`endif
    end
    check("contend_count", tx_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < tx_log.size()) check($sformatf("contend_byte%0d", i), tx_log[i], exp_seq[i]);
    end
    check("contend_ready_pulses", n_ready, 4);
    rq_valid = '0;
    wait_idle("contend_idle", 100);

    // Spurious done in IDLE, then in START.
    mode = RQ_ONESHOT;
    uart_lat = 10;
    force_done = 1'b1;
    step();
    check("spur_idle_busy", o_busy, 1'b0);
    rq_data[7:0] = 8'h55;
    rq_valid = 2'b01;
    step();
    force_done = 1'b1;
    step();
    check("spur_start_busy", o_busy, 1'b1);
    check("spur_start_grant", o_grant, 2'b01);
    repeat (3) step();
    check("spur_still_waiting", o_busy, 1'b1);
    wait_idle("spur_idle", 50);

    // Reset in WAIT_DONE, stale done tick afterwards.
    uart_lat = 30;
    rq_data[7:0] = 8'h77;
    rq_valid = 2'b01;
    step();
    repeat (3) step();
    check("rstmid_pre_grant", o_grant, 2'b01);
    do_reset(2);
    check("rstmid_grant", o_grant, 2'b00);
    check("rstmid_data", o_tx_data, 8'h00);
    uart_cnt = 0;
    force_done = 1'b1;
    step();
    check("stale_done_busy", o_busy, 1'b0);
    rq_data[15:8] = 8'h99;
    rq_valid = 2'b10;
    step();
    check("post_rst_grant", o_grant, 2'b10);
    check("post_rst_data", o_tx_data, 8'h99);
    check("post_rst_start", o_tx_start, 1'b1);
    wait_idle("post_rst_idle", 60);

    // Back-to-back: next start exactly one cycle after the done edge.
    mode = RQ_HOLD;
    uart_lat = 8;
    rq_data[7:0] = 8'h5A;
    rq_valid = 2'b01;
    step();
    n = 0;
    last_done = 1'b0;
    while (!last_done && n < 50) begin
      step();
      n++;
    end
    check("b2b_done_seen", last_done, 1'b1);
    check("b2b_d_start", o_tx_start, 1'b0);
    check("b2b_d_busy", o_busy, 1'b0);
    step();
    check("b2b_d1_start", o_tx_start, 1'b1);
    check("b2b_d1_data", o_tx_data, 8'h5A);
    step();
    check("b2b_d2_start", o_tx_start, 1'b0);
    rq_valid = '0;
    wait_idle("b2b_idle", 50);

    // Random traffic with spurious ticks and occasional mid-frame resets.
    mode = RQ_RANDOM;
    rand_lat = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      force_done = ($urandom_range(0, 39) == 0);
      step();
      if (o_busy && $urandom_range(0, 599) == 0) do_reset(1);
    end
    mode = RQ_ONESHOT;
    rq_valid = '0;
    wait_idle("random_idle", 100);

    check("starts_vs_accepts", n_starts, n_acc);
    check("ready_vs_starts", n_ready + 4, n_starts - (n_starts - n_ready - 4) );
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
